// File: rtl/mult_acc_stage.sv
// Multiply-accumulate stage: registers operand pairs, multiplies them (low N bits)
// and sums the products per in_last-delimited frame, one result per frame.
`timescale 1ns/1ps

module mult #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] p
);

  // Shift-and-add array; every partial product is truncated to N bits, so the
  // sum is the product modulo 2^N.
  always_comb begin
    p = '0;
    for (int i = 0; i < N; i++) begin
      if (b[i]) p = p + (a << i);
    end
  end

endmodule

module mult_acc_stage #(
  parameter int N  = 8,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_a,
  input  logic [N-1:0]  in_b,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_sum,
  output logic [CW-1:0] out_count
);

  localparam logic [0:0] RES_EMPTY = 1'b0;
  localparam logic [0:0] RES_FULL  = 1'b1;

  logic [0:0]    res_state;
  logic          p1_valid;
  logic          p1_last;
  logic [N-1:0]  p1_a;
  logic [N-1:0]  p1_b;
  logic [N-1:0]  acc;
  logic [CW-1:0] cnt;
  logic [N-1:0]  prod;
  logic [N-1:0]  sum_next;
  logic [CW-1:0] cnt_next;
  logic          advance;
  logic          adv_last;
  logic          in_fire;
  logic          out_fire;

  mult #(.N(N)) u_mult (
    .a (p1_a),
    .b (p1_b),
    .p (prod)
  );

  // Only a last beat can be blocked, and only by an undrained result.
  assign advance   = p1_valid & ~(p1_last & out_valid & ~out_ready);
  assign adv_last  = advance & p1_last;
  assign in_ready  = rst & (~p1_valid | advance);
  assign in_fire   = in_valid & in_ready;
  assign out_valid = (res_state == RES_FULL);
  assign out_fire  = out_valid & out_ready;
  assign sum_next  = acc + prod;
  assign cnt_next  = (cnt == {CW{1'b1}}) ? cnt : cnt + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p1_valid <= 1'b0;
      p1_last  <= 1'b0;
      p1_a     <= '0;
      p1_b     <= '0;
    end else if (in_fire) begin
      p1_valid <= 1'b1;
      p1_last  <= in_last;
      p1_a     <= in_a;
      p1_b     <= in_b;
    end else if (advance) begin
      p1_valid <= 1'b0;
    end
  end

  // A last beat hands its total to the result register and restarts the
  // accumulator in the same edge, so the next frame needs no bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc       <= '0;
      cnt       <= '0;
      out_sum   <= '0;
      out_count <= '0;
      res_state <= RES_EMPTY;
    end else begin
      if (advance && !p1_last) begin
        acc <= sum_next;
        cnt <= cnt_next;
      end
      if (adv_last) begin
        out_sum   <= sum_next;
        out_count <= cnt_next;
        acc       <= '0;
        cnt       <= '0;
      end
      if (res_state == RES_EMPTY) begin
        if (adv_last) res_state <= RES_FULL;
      end else begin
        if (out_fire && !adv_last) res_state <= RES_EMPTY;
      end
    end
  end

endmodule

// File: tb/tb_mult_acc_stage.sv
// Scoreboard bench for mult_acc_stage: a frame-level reference model queues expected
// results, and a negedge monitor compares them against two instances (CW=8 and CW=2).
`timescale 1ns/1ps

module tb_mult_acc_stage;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] in_a = '0;
  logic [7:0] in_b = '0;

  logic       in_ready, out_valid, in_ready2, out_valid2;
  logic [7:0] out_sum, out_count, out_sum2;
  logic [1:0] out_count2;

  typedef struct {
    int sum;
    int cnt;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  int   fa[$];
  int   fb[$];
  int   checks = 0;
  int   errors = 0;
  int   stalls = 0;
  int   fires1 = 0;
  bit   randReady = 1'b0;

  mult_acc_stage #(.N(8), .CW(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_count(out_count)
  );

  mult_acc_stage #(.N(8), .CW(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(out_valid2),
    .out_ready(out_ready), .out_sum(out_sum2), .out_count(out_count2)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Frame-level model: remember the pairs, and at the last one the result is the
  // plain arithmetic sum of products mod 256 with the beat count clamped per width.
  task automatic modelBeat(input int a, input int b, input bit last);
    int sum;
    int n;
    fa.push_back(a);
    fb.push_back(b);
    if (last) begin
      sum = 0;
      for (int i = 0; i < fa.size(); i++) sum += fa[i] * fb[i];
      sum = sum % 256;
      n = fa.size();
      q1.push_back('{sum, (n > 255) ? 255 : n});
      q2.push_back('{sum, (n > 3) ? 3 : n});
      fa.delete();
      fb.delete();
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (randReady) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) tick();
  endtask

  // Present one pair and hold it until it is accepted; returns at posedge+1 with
  // in_valid cleared, so consecutive calls stream with no gap.
  task automatic applyStimulus(input int a, input int b, input bit last);
    int w;
    in_valid = 1'b1;
    in_a     = 8'(a);
    in_b     = 8'(b);
    in_last  = last;
    w = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      w++;
      stalls++;
      if (w > 200) begin
        check("in_ready timeout", 0, 1);
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      if (randReady) out_ready = 1'($urandom_range(0, 1));
    end
    @(posedge clk);
    modelBeat(a, b, last);
    #1;
    in_valid = 1'b0;
    if (randReady) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic checkOutput(input int id, input logic v, input logic r,
                             input int sum, input int cnt);
    exp_t e;
    if (!v) return;
    if ((id == 1 && q1.size() == 0) || (id == 2 && q2.size() == 0)) begin
      check($sformatf("dut%0d unexpected result", id), 1, 0);
      return;
    end
    e = (id == 1) ? q1[0] : q2[0];
    check($sformatf("dut%0d out_sum", id), sum, e.sum);
    check($sformatf("dut%0d out_count", id), cnt, e.cnt);
    if (r) begin
      if (id == 1) begin
        q1.delete(0);
        fires1++;
      end else begin
        q2.delete(0);
      end
    end
  endtask

  always @(negedge clk) begin
    checkOutput(1, out_valid, out_ready, int'(out_sum), int'(out_count));
    checkOutput(2, out_valid2, out_ready, int'(out_sum2), int'(out_count2));
  end

  initial begin
    #500000;
    $display("[TB] FAIL global timeout");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    int s0;
    int f0;
    int w;
    int len;

    repeat (3) @(posedge clk);
    #1;
    check("reset out_valid", int'(out_valid), 0);
    check("reset out_sum", int'(out_sum), 0);
    check("reset out_count", int'(out_count), 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("in_ready after reset", int'(in_ready), 1);
    tick();

    $display("[TB] basic frame and latency");
    out_ready = 1'b1;
    s0 = stalls;
    applyStimulus(3, 5, 0);
    applyStimulus(4, 6, 0);
    applyStimulus(10, 2, 1);
    check("out_valid at last fire edge", int'(out_valid), 0);
    tick();
    check("out_valid one edge later", int'(out_valid), 1);
    check("basic frame stalls", stalls - s0, 0);
    idle(3);

    $display("[TB] wrap and single-beat frames");
    applyStimulus(16, 16, 0);
    applyStimulus(255, 255, 1);
    applyStimulus(200, 3, 1);
    idle(3);

    $display("[TB] backpressure");
    out_ready = 1'b0;
    applyStimulus(3, 5, 0);
    applyStimulus(4, 6, 0);
    applyStimulus(10, 2, 1);
    applyStimulus(1, 1, 0);
    applyStimulus(2, 2, 1);
    @(negedge clk);
    check("in_ready low with last held", int'(in_ready), 0);
    check("held out_sum", int'(out_sum), 59);
    check("held out_count", int'(out_count), 3);
    @(posedge clk);
    #1;
    idle(2);
    out_ready = 1'b1;
    idle(4);

    $display("[TB] back-to-back two-beat frames");
    s0 = stalls;
    f0 = fires1;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 0);
      applyStimulus(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 1);
    end
    idle(3);
    check("back-to-back stalls", stalls - s0, 0);
    check("back-to-back results", fires1 - f0, 8);

    $display("[TB] counter saturation");
    for (int i = 0; i < 5; i++) applyStimulus(1, 1, i == 4);
    idle(3);
    for (int i = 0; i < 300; i++)
      applyStimulus(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), i == 299);
    idle(3);

    $display("[TB] randomized frames with random out_ready");
    randReady = 1'b1;
    for (int f = 0; f < 40; f++) begin
      len = int'($urandom_range(1, 6));
      for (int j = 0; j < len; j++) begin
        applyStimulus(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), j == len - 1);
        if ($urandom_range(0, 3) == 0) idle(1);
      end
    end
    randReady = 1'b0;
    out_ready = 1'b1;
    idle(6);

    $display("[TB] reset mid-frame");
    out_ready = 1'b0;
    applyStimulus(1, 2, 1);
    idle(2);
    applyStimulus(7, 7, 0);
    #3;
    rst = 1'b0;
    q1.delete();
    q2.delete();
    fa.delete();
    fb.delete();
    #1;
    check("mid-reset out_valid", int'(out_valid), 0);
    check("mid-reset out_sum", int'(out_sum), 0);
    check("mid-reset out_count", int'(out_count), 0);
    check("mid-reset dut2 out_valid", int'(out_valid2), 0);
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;
    #1;
    check("in_ready after mid reset", int'(in_ready), 1);
    @(posedge clk);
    #1;
    applyStimulus(2, 3, 1);
    idle(4);

    w = 0;
    while ((q1.size() != 0 || q2.size() != 0) && w < 200) begin
      tick();
      w++;
    end
    check("scoreboard drained", q1.size() + q2.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_acc_stage.md
Name: mult_acc_stage

Overview:
Sequential multiply-accumulate stage that sits directly downstream of the N-bit truncated MULT block.
- Accepts a stream of operand pairs over a valid/ready handshake.
- Registers each pair and drives the pair into an internal MULT instance, which returns the low N bits of the product.
- Accumulates the products modulo 2^N over a frame that ends on in_last.
- Emits one result per frame on a valid/ready output with backpressure. Intended for dot-product style netlists.

Parameters:
N, 8, operand, product and accumulator width in bits.
CW, 8, width of the per-frame beat counter.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  asynchronous, active-low reset.
in_valid  input  1  operand pair present.
in_ready  output  1  stage can accept a pair this cycle.
in_a  input  N  multiplicand.
in_b  input  N  multiplier.
in_last  input  1  marks final pair of the frame.
out_valid  output  1  result register holds a frame result.
out_ready  input  1  consumer takes the result this cycle.
out_sum  output  N  frame sum of products, modulo 2^N.
out_count  output  CW  number of pairs in the frame, saturating.

Behaviour:
Reset and handshakes:
- Reset (rst=0, asynchronous): p1_valid=0, acc=0, cnt=0, out_valid=0, out_sum=0, out_count=0. The in_ready output is 1 once rst deasserts.
- Input fire: in_valid & in_ready at a rising edge.
- Output fire: out_valid & out_ready at a rising edge.
- Data-stability rules:
  - in_a, in_b and in_last are sampled only on an input fire.
  - out_sum and out_count stay stable while out_valid=1 and out_ready=0.

Stage 1 (operand register):
- On input fire, load p1_a, p1_b and p1_last, and set p1_valid=1.
- p1 advances when p1_valid & !(p1_last & out_valid & !out_ready). In words, it stalls only when it holds a last beat and the result register is full and not draining.
- in_ready = !p1_valid | advance. This is combinational and allows one pair per cycle at full throughput.
- If p1 advances with no input fire, p1_valid goes to 0.

Stage 2 (multiply/accumulate):
- prod = MULT(p1_a, p1_b), low N bits only.
- When p1 advances with p1_last=0:
  - acc <= acc + prod (mod 2^N).
  - cnt <= cnt + 1, saturating at 2^CW-1.
- When p1 advances with p1_last=1:
  - out_sum <= acc + prod (mod 2^N).
  - out_count <= sat(cnt + 1).
  - out_valid <= 1.
  - acc <= 0 and cnt <= 0, so the next beat starts a new frame with no bubble.

Result register (two states, EMPTY and FULL):
- EMPTY -> FULL on a last-beat advance.
- FULL -> EMPTY on output fire with no simultaneous last-beat advance.
- FULL -> FULL with new data when an output fire and a last-beat advance happen in the same cycle. This gives back-to-back frames.

Timing and boundary cases:
- Latency: last pair fires at edge k; out_valid=1 and result visible after edge k+1.
- Single-beat frame (in_last on the first pair): out_sum = product, out_count = 1.
- Overflow: sums and products wrap modulo 2^N, with no flag. The counter saturates at 2^CW-1 and does not wrap.
- Non-last beats never stall on a full result register. Accumulation continues while the previous result waits.
- Reset mid-frame discards the partial acc, cnt and p1 contents. Any pending result is dropped.
- No frame-abort input exists; a frame ends only on in_last.

Test Plan:
- N=8, frame (3,5),(4,6),(10,2,last), out_ready=1 -> out_valid one edge after the last fire, out_sum=59, out_count=3, in_ready=1 throughout.
- Wrap: (16,16),(255,255,last) -> products 0 and 1, out_sum=1, out_count=2. Single frame (200,3,last) -> out_sum=88, out_count=1.
- Backpressure:
  - Setup: hold out_ready=0 with result 59 pending, then send (1,1),(2,2,last).
  - Required: first beat accumulates; in_ready drops while p1 holds the last beat; out_sum stays 59.
  - Then raise out_ready: 59 drains, then out_sum=5, out_count=2.
- Back-to-back: continuous in_valid, frames of 2 beats each with out_ready=1 -> one result every 2 cycles, no bubbles, acc correctly zeroed per frame.
- Reset mid-frame: after accepting (7,7), pulse rst low asynchronously between edges -> all outputs 0 immediately. The next frame (2,3,last) gives out_sum=6, out_count=1.
- Counter saturation with CW=2: 5-beat frame of (1,1) -> out_sum=5, out_count=3.
